sdram_phase_sweep: RTL and testbench

Automatic SDRAM clock-phase calibrator for the memtest design.
- Steps the ECP5 PLL dynamic phase of the chip-facing SDRAM clock through every position of one full rotation.
- At each position it resets `mem_tester`, lets it run for a dwell period and grades the position pass/fail.
- It then finds the widest circular window of passing positions and parks the PLL at its centre.
- It replaces manual button phase stepping and drives the PLL `phasedir`/`phasestep`/`phaseloadreg` ports directly. It runs in the `mem_tester` clock domain.

---
 rtl/sdram_phase_pkg.sv | 19 +
 rtl/sdram_phase_sweep_circ_run_scan.sv | 71 +++++++
 rtl/sdram_phase_sweep.sv | 237 +++++++++++++++++++++++
 tb/tb_sdram_phase_sweep.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sdram_phase_pkg.sv
// Shared types and widths for the SDRAM clock-phase calibrator.
package sdram_phase_pkg;

  localparam int unsigned POS_W = 8;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_TRST   = 4'd1,
    ST_DWELL  = 4'd2,
    ST_SAMPLE = 4'd3,
    ST_STEP   = 4'd4,
    ST_SETTLE = 4'd5,
    ST_SCAN   = 4'd6,
    ST_MOVE   = 4'd7,
    ST_DONE   = 4'd8
  } sweep_state_e;

endpackage

// File: rtl/sdram_phase_sweep_circ_run_scan.sv
// Serial longest-run finder over a circular map presented twice in index order.
module circ_run_scan
  import sdram_phase_pkg::*;
#(
  parameter int unsigned STEPS = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             map_bit,
  input  logic [POS_W-1:0] idx,
  output logic [POS_W-1:0] best_start,
  output logic [POS_W-1:0] best_len
);

  localparam logic [POS_W-1:0] LEN_CAP   = POS_W'(STEPS);
  localparam logic [POS_W:0]   START_LIM = (POS_W + 1)'(STEPS);

  logic [POS_W-1:0] run_start_r;
  logic [POS_W-1:0] run_len_r;
  logic [POS_W-1:0] best_start_r;
  logic [POS_W-1:0] best_len_r;
  logic [POS_W-1:0] run_start_nxt_s;
  logic [POS_W-1:0] run_len_nxt_s;
  logic             take_s;

  // Extend or restart the current run and decide whether it beats the best so far
  always_comb begin
    run_start_nxt_s = run_start_r;
    run_len_nxt_s   = run_len_r;
    if (!map_bit) begin
      run_len_nxt_s = {POS_W{1'b0}};
    end else if (run_len_r == {POS_W{1'b0}}) begin
      run_start_nxt_s = idx;
      run_len_nxt_s   = 8'd1;
    end else if (run_len_r == LEN_CAP) begin
      run_len_nxt_s = LEN_CAP;
    end else begin
      run_len_nxt_s = run_len_r + 8'd1;
    end
    // Runs starting in the second lap are only repeats of first-lap runs
    take_s = (run_len_nxt_s > best_len_r) && ({1'b0, run_start_nxt_s} < START_LIM);
  end

  // Run and best-result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_start_r  <= {POS_W{1'b0}};
      run_len_r    <= {POS_W{1'b0}};
      best_start_r <= {POS_W{1'b0}};
      best_len_r   <= {POS_W{1'b0}};
    end else if (clr) begin
      run_start_r  <= {POS_W{1'b0}};
      run_len_r    <= {POS_W{1'b0}};
      best_start_r <= {POS_W{1'b0}};
      best_len_r   <= {POS_W{1'b0}};
    end else if (en) begin
      run_start_r <= run_start_nxt_s;
      run_len_r   <= run_len_nxt_s;
      if (take_s) begin
        best_start_r <= run_start_nxt_s;
        best_len_r   <= run_len_nxt_s;
      end
    end
  end

  assign best_start = best_start_r;
  assign best_len   = best_len_r;

endmodule

// File: rtl/sdram_phase_sweep.sv
// Sweeps the SDRAM PLL output phase, grades each position with mem_tester and parks at the widest passing window's centre.
module sdram_phase_sweep
  import sdram_phase_pkg::*;
#(
  parameter int unsigned STEPS    = 64,
  parameter int unsigned DWELL    = 1048576,
  parameter int unsigned PULSE_W  = 4,
  parameter int unsigned SETTLE   = 256,
  parameter int unsigned RST_W    = 16,
  parameter int unsigned PASS_MIN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pll_locked,
  input  logic [CNT_W-1:0] passcount,
  input  logic [CNT_W-1:0] failcount,
  output logic             phasedir,
  output logic             phasestep,
  output logic             phaseloadreg,
  output logic             tester_rst_n,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [STEPS-1:0] pass_map,
  output logic [POS_W-1:0] best_pos,
  output logic [POS_W-1:0] win_len,
  output logic [POS_W-1:0] cur_pos
);

  localparam int unsigned      LOG_S        = $clog2(STEPS);
  localparam logic [POS_W-1:0] POS_MASK     = POS_W'(STEPS - 1);
  localparam logic [POS_W-1:0] SCAN_LAST    = POS_W'(2 * STEPS - 1);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_W - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] PASS_MIN_C   = CNT_W'(PASS_MIN);

  sweep_state_e     state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [POS_W-1:0] scan_idx_r;
  logic [POS_W-1:0] move_cnt_r;
  logic             move_mode_r;
  logic             move_init_r;
  logic             phasestep_r;
  logic             tester_rst_n_r;
  logic             busy_r;
  logic             done_r;
  logic             fail_r;
  logic [STEPS-1:0] pass_map_r;
  logic [POS_W-1:0] best_pos_r;
  logic [POS_W-1:0] win_len_r;
  logic [POS_W-1:0] cur_pos_r;

  logic             sample_pass_s;
  logic [POS_W-1:0] next_pos_s;
  logic             scan_clr_s;
  logic             scan_en_s;
  logic             scan_bit_s;
  logic [POS_W-1:0] best_start_s;
  logic [POS_W-1:0] best_len_s;
  logic [POS_W-1:0] centre_s;
  logic [POS_W-1:0] move_calc_s;

  // Position grading, wrap arithmetic and window-centre selection
  always_comb begin
    sample_pass_s = (failcount == {CNT_W{1'b0}}) && (passcount >= PASS_MIN_C);
    next_pos_s    = (cur_pos_r + 8'd1) & POS_MASK;
    scan_clr_s    = (state_r == ST_SAMPLE);
    scan_en_s     = (state_r == ST_SCAN);
    scan_bit_s    = pass_map_r[scan_idx_r[LOG_S-1:0]];
    if (best_len_s == {POS_W{1'b0}}) begin
      centre_s = {POS_W{1'b0}};
    end else begin
      centre_s = (best_start_s + {1'b0, best_len_s[POS_W-1:1]}) & POS_MASK;
    end
    move_calc_s = (centre_s - cur_pos_r) & POS_MASK;
  end

  circ_run_scan #(
    .STEPS (STEPS)
  ) u_scan (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (scan_clr_s),
    .en         (scan_en_s),
    .map_bit    (scan_bit_s),
    .idx        (scan_idx_r),
    .best_start (best_start_s),
    .best_len   (best_len_s)
  );

  // Sweep sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      cnt_r          <= {CNT_W{1'b0}};
      scan_idx_r     <= {POS_W{1'b0}};
      move_cnt_r     <= {POS_W{1'b0}};
      move_mode_r    <= 1'b0;
      move_init_r    <= 1'b0;
      phasestep_r    <= 1'b0;
      tester_rst_n_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      fail_r         <= 1'b0;
      pass_map_r     <= {STEPS{1'b0}};
      best_pos_r     <= {POS_W{1'b0}};
      win_len_r      <= {POS_W{1'b0}};
      cur_pos_r      <= {POS_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && pll_locked) begin
            done_r         <= 1'b0;
            fail_r         <= 1'b0;
            pass_map_r     <= {STEPS{1'b0}};
            cur_pos_r      <= {POS_W{1'b0}};
            busy_r         <= 1'b1;
            tester_rst_n_r <= 1'b0;
            cnt_r          <= {CNT_W{1'b0}};
            move_mode_r    <= 1'b0;
            state_r        <= ST_TRST;
          end
        end
        ST_TRST: begin
          if (cnt_r == RST_LAST) begin
            tester_rst_n_r <= 1'b1;
            cnt_r          <= {CNT_W{1'b0}};
            state_r        <= ST_DWELL;
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        ST_DWELL: begin
          // Lost lock invalidates the test; rerun this position from reset
          if (!pll_locked) begin
            tester_rst_n_r <= 1'b0;
            cnt_r          <= {CNT_W{1'b0}};
            state_r        <= ST_TRST;
          end else if (cnt_r == DWELL_LAST) begin
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_SAMPLE;
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        ST_SAMPLE: begin
          pass_map_r[cur_pos_r[LOG_S-1:0]] <= sample_pass_s;
          if (cur_pos_r == POS_MASK) begin
            tester_rst_n_r <= 1'b0;
            scan_idx_r     <= {POS_W{1'b0}};
            state_r        <= ST_SCAN;
          end else begin
            phasestep_r <= 1'b1;
            cnt_r       <= {CNT_W{1'b0}};
            move_mode_r <= 1'b0;
            state_r     <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (cnt_r == PULSE_LAST) begin
            phasestep_r <= 1'b0;
            cur_pos_r   <= next_pos_s;
            cnt_r       <= {CNT_W{1'b0}};
            state_r     <= ST_SETTLE;
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        ST_SETTLE: begin
          if (cnt_r != SETTLE_LAST) begin
            cnt_r <= cnt_r + 32'd1;
          end else if (pll_locked) begin
            cnt_r <= {CNT_W{1'b0}};
            if (move_mode_r) begin
              move_cnt_r <= move_cnt_r - 8'd1;
              state_r    <= ST_MOVE;
            end else begin
              tester_rst_n_r <= 1'b0;
              state_r        <= ST_TRST;
            end
          end
        end
        ST_SCAN: begin
          if (scan_idx_r == SCAN_LAST) begin
            move_init_r <= 1'b1;
            state_r     <= ST_MOVE;
          end else begin
            scan_idx_r <= scan_idx_r + 8'd1;
          end
        end
        ST_MOVE: begin
          // First cycle latches the scan result once the last index has settled
          if (move_init_r) begin
            move_init_r <= 1'b0;
            win_len_r   <= best_len_s;
            best_pos_r  <= centre_s;
            fail_r      <= (best_len_s == {POS_W{1'b0}});
            move_cnt_r  <= move_calc_s;
          end else if (move_cnt_r == {POS_W{1'b0}}) begin
            state_r <= ST_DONE;
          end else begin
            phasestep_r <= 1'b1;
            cnt_r       <= {CNT_W{1'b0}};
            move_mode_r <= 1'b1;
            state_r     <= ST_STEP;
          end
        end
        ST_DONE: begin
          tester_rst_n_r <= 1'b1;
          busy_r         <= 1'b0;
          done_r         <= 1'b1;
          move_mode_r    <= 1'b0;
          state_r        <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign phasedir     = 1'b0;
  assign phaseloadreg = 1'b0;
  assign phasestep    = phasestep_r;
  assign tester_rst_n = tester_rst_n_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign fail         = fail_r;
  assign pass_map     = pass_map_r;
  assign best_pos     = best_pos_r;
  assign win_len      = win_len_r;
  assign cur_pos      = cur_pos_r;

endmodule

// File: tb/tb_sdram_phase_sweep.sv
// Directed bench for sdram_phase_sweep: modelled tester, pulse monitor and hand-computed results.
module tb_sdram_phase_sweep;

  localparam int unsigned STEPS  = 8;
  localparam int unsigned SETTLE = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        pll_locked;
  logic [31:0] passcount;
  logic [31:0] failcount;
  logic        phasedir;
  logic        phasestep;
  logic        phaseloadreg;
  logic        tester_rst_n;
  logic        busy;
  logic        done;
  logic        fail;
  logic [7:0]  pass_map;
  logic [7:0]  best_pos;
  logic [7:0]  win_len;
  logic [7:0]  cur_pos;

  logic [7:0]  tester_mask = 8'h00;

  int checks = 0;
  int errors = 0;

  sdram_phase_sweep #(
    .STEPS    (STEPS),
    .DWELL    (64),
    .PULSE_W  (4),
    .SETTLE   (SETTLE),
    .RST_W    (16),
    .PASS_MIN (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pll_locked   (pll_locked),
    .passcount    (passcount),
    .failcount    (failcount),
    .phasedir     (phasedir),
    .phasestep    (phasestep),
    .phaseloadreg (phaseloadreg),
    .tester_rst_n (tester_rst_n),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .pass_map     (pass_map),
    .best_pos     (best_pos),
    .win_len      (win_len),
    .cur_pos      (cur_pos)
  );

  always #5 clk = ~clk;

  // Tester model: a passing position counts passes, a failing one counts errors
  assign passcount = (tester_rst_n && tester_mask[cur_pos[2:0]]) ? 32'd10 : 32'd0;
  assign failcount = (tester_rst_n && !tester_mask[cur_pos[2:0]]) ? 32'd3 : 32'd0;

  // Pulse and reset-edge monitor
  logic ps_q   = 1'b0;
  logic trst_q = 1'b0;
  int   pulse_cnt  = 0;
  int   low_run    = 1000;
  int   gap_bad    = 0;
  int   trst_falls = 0;
  int   tie_bad    = 0;
  always @(posedge clk) begin
    if (phasestep && !ps_q) begin
      pulse_cnt++;
      if (low_run < SETTLE) gap_bad++;
    end
    low_run = phasestep ? 0 : low_run + 1;
    if (trst_q && !tester_rst_n) trst_falls++;
    if (phasedir || phaseloadreg) tie_bad++;
    ps_q   = phasestep;
    trst_q = tester_rst_n;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  int base_pulses;
  int base_trst;

  task automatic kick(input string name);
    base_pulses = pulse_cnt;
    base_trst   = trst_falls;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check_val({name, "_busy_rise"}, 32'(busy), 32'd1);
  endtask

  task automatic finish_sweep(input string name, input logic [7:0] exp_map,
                              input logic [7:0] exp_len, input logic [7:0] exp_pos,
                              input logic exp_fail, input int exp_pulses);
    for (int k = 0; k < 5000 && !done; k++) @(negedge clk);
    check_val({name, "_done"}, 32'(done), 32'd1);
    check_val({name, "_busy"}, 32'(busy), 32'd0);
    check_val({name, "_map"}, 32'(pass_map), 32'(exp_map));
    check_val({name, "_len"}, 32'(win_len), 32'(exp_len));
    check_val({name, "_pos"}, 32'(best_pos), 32'(exp_pos));
    check_val({name, "_fail"}, 32'(fail), 32'(exp_fail));
    check_val({name, "_cur"}, 32'(cur_pos), 32'(exp_pos));
    check_val({name, "_pulses"}, 32'(pulse_cnt - base_pulses), 32'(exp_pulses));
    check_val({name, "_trst_rel"}, 32'(tester_rst_n), 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("reset_outputs",
              32'({phasedir, phasestep, phaseloadreg, tester_rst_n, busy, done, fail, pass_map,
                   best_pos, win_len, cur_pos}), 32'd0);

    // Window 2..4
    tester_mask = 8'b00011100;
    kick("win");
    finish_sweep("win", 8'b00011100, 8'd3, 8'd3, 1'b0, 11);

    // Wrapped window 6,7,0,1
    tester_mask = 8'b11000011;
    kick("wrap");
    finish_sweep("wrap", 8'b11000011, 8'd4, 8'd0, 1'b0, 8);

    // Nothing passes
    tester_mask = 8'b00000000;
    kick("none");
    finish_sweep("none", 8'b00000000, 8'd0, 8'd0, 1'b1, 8);

    // Everything passes, with a start request while busy
    tester_mask = 8'b11111111;
    kick("all");
    for (int k = 0; k < 3000 && cur_pos != 8'd2; k++) @(negedge clk);
    check_val("all_reach_pos2", 32'(cur_pos), 32'd2);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    check_val("busy_start_cur", 32'(cur_pos), 32'd2);
    check_val("busy_start_busy", 32'(busy), 32'd1);
    finish_sweep("all", 8'b11111111, 8'd8, 8'd4, 1'b0, 12);

    // Lock loss mid-dwell at position 3
    tester_mask = 8'b00011100;
    kick("lock");
    for (int k = 0; k < 3000 && cur_pos != 8'd3; k++) @(negedge clk);
    for (int k = 0; k < 100 && tester_rst_n; k++) @(negedge clk);
    for (int k = 0; k < 100 && !tester_rst_n; k++) @(negedge clk);
    check_val("lock_in_dwell", 32'(tester_rst_n), 32'd1);
    repeat (10) @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk);
    check_val("lock_retrst", 32'(tester_rst_n), 32'd0);
    check_val("lock_cur", 32'(cur_pos), 32'd3);
    pll_locked = 1'b1;
    finish_sweep("lock", 8'b00011100, 8'd3, 8'd3, 1'b0, 11);
    check_val("lock_trst_count", 32'(trst_falls - base_trst), 32'd10);

    // Asynchronous reset during a step pulse
    tester_mask = 8'b11111111;
    kick("arst");
    for (int k = 0; k < 3000 && !(phasestep && cur_pos == 8'd1); k++) @(negedge clk);
    check_val("arst_in_step", 32'(phasestep), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("arst_outputs",
              32'({phasestep, tester_rst_n, busy, done, fail, pass_map, best_pos, win_len,
                   cur_pos}), 32'd0);
    rst_n = 1'b1;

    // Start without PLL lock is not accepted
    pll_locked = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    check_val("nolock_start", 32'(busy), 32'd0);
    pll_locked = 1'b1;

    // Tie between runs {1,2} and {5,6}
    tester_mask = 8'b01100110;
    kick("tie");
    finish_sweep("tie", 8'b01100110, 8'd2, 8'd2, 1'b0, 10);

    check_val("pulse_spacing", 32'(gap_bad), 32'd0);
    check_val("tie_offs", 32'(tie_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
